ex_result_buffer: RTL and testbench

Execute-to-memory stage buffer directly downstream of the ALU shifter. It captures the shifter/ALU result, destination register and write-back enable from execute. It presents them to the memory stage through a valid/ready handshake. A 2-entry skid structure keeps the registered ex_ready from throttling throughput, and flush support lets branches squash in-flight results.

---
 rtl/ex_result_buffer_pkg.sv | 20 ++
 rtl/ex_result_buffer_pipe_slot.sv | 37 +++
 rtl/ex_result_buffer.sv | 109 ++++++++++
 tb/tb_ex_result_buffer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_result_buffer_pkg.sv
// Shared constants for the execute-to-memory result buffer and the ALU/shifter op encodings.
package ex_result_buffer_pkg;

  localparam int DEF_OPD_LENGTH = 32;
  localparam int DEF_REG_ADDR_W = 5;
  localparam int ZERO_REG       = 0;
  localparam int DEF_PAYLOAD_W  = DEF_OPD_LENGTH + DEF_REG_ADDR_W + 1;

  typedef enum logic [2:0] {
    ALU_OP_ADD = 3'd0,
    ALU_OP_SUB = 3'd1,
    ALU_OP_SLL = 3'd2,
    ALU_OP_SRL = 3'd3,
    ALU_OP_SRA = 3'd4,
    ALU_OP_AND = 3'd5,
    ALU_OP_OR  = 3'd6,
    ALU_OP_XOR = 3'd7
  } alu_op_select_t;

endpackage

// File: rtl/ex_result_buffer_pipe_slot.sv
// One buffer slot: payload register plus valid bit, with load enable and synchronous clear.
module ex_result_buffer_pipe_slot
  import ex_result_buffer_pkg::*;
#(
  parameter int WIDTH = DEF_PAYLOAD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             valid_en,
  input  logic             valid_in,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Clear only drops the valid bit; the payload keeps its last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (valid_en) begin
      valid <= valid_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
    end else if (load) begin
      data <= data_in;
    end
  end

endmodule

// File: rtl/ex_result_buffer.sv
// Execute-to-memory result buffer: output slot plus skid slot behind a valid/ready handshake.
// Optional operand-forwarding ports are enabled with the EX_RESULT_FWD_EN macro.
module ex_result_buffer
  import ex_result_buffer_pkg::*;
#(
  parameter int OPD_LENGTH = DEF_OPD_LENGTH,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [OPD_LENGTH-1:0] ex_result,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr,
  input  logic                  ex_wb_en,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [OPD_LENGTH-1:0] mem_result,
  output logic [REG_ADDR_W-1:0] mem_rd_addr,
  output logic                  mem_wb_en,
  output logic [1:0]            occupancy
`ifdef EX_RESULT_FWD_EN
  ,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_rd_addr,
  output logic [OPD_LENGTH-1:0] fwd_result
`endif
);

  localparam int PW = OPD_LENGTH + REG_ADDR_W + 1;

  logic          out_valid;
  logic          skid_valid;
  logic [PW-1:0] out_payload;
  logic [PW-1:0] skid_payload;
  logic [PW-1:0] in_payload;
  logic [PW-1:0] out_data_in;
  logic          in_wb_en;
  logic          accept;
  logic          drain;
  logic          out_free;
  logic          out_valid_en;
  logic          out_load;
  logic          skid_valid_en;
  logic          skid_load;

  // Writes to the zero register are neutralised once, here, so later stages never see them.
  assign in_wb_en   = ex_wb_en & (ex_rd_addr != REG_ADDR_W'(ZERO_REG));
  assign in_payload = {ex_result, ex_rd_addr, in_wb_en};

  assign ex_ready  = ~skid_valid;
  assign accept    = ex_valid & ex_ready & ~flush;
  assign drain     = out_valid & mem_ready;
  assign out_free  = ~out_valid | drain;

  assign out_valid_en = out_free;
  assign out_load     = ~flush & out_free & (skid_valid | accept);
  assign out_data_in  = skid_valid ? skid_payload : in_payload;

  // The skid only fills when the output slot is stuck, so it never overtakes it.
  assign skid_valid_en = (out_free & skid_valid) | (~out_free & accept);
  assign skid_load     = accept & (skid_valid | ~out_free);

  ex_result_buffer_pipe_slot #(.WIDTH(PW)) u_out_slot (
    .clk      (clk),
    .rst      (rst),
    .clear    (flush),
    .valid_en (out_valid_en),
    .valid_in (skid_valid | accept),
    .load     (out_load),
    .data_in  (out_data_in),
    .valid    (out_valid),
    .data     (out_payload)
  );

  ex_result_buffer_pipe_slot #(.WIDTH(PW)) u_skid_slot (
    .clk      (clk),
    .rst      (rst),
    .clear    (flush),
    .valid_en (skid_valid_en),
    .valid_in (accept),
    .load     (skid_load),
    .data_in  (in_payload),
    .valid    (skid_valid),
    .data     (skid_payload)
  );

  assign mem_valid = out_valid;
  assign {mem_result, mem_rd_addr, mem_wb_en} = out_payload;
  assign occupancy = {1'b0, out_valid} + {1'b0, skid_valid};

`ifdef EX_RESULT_FWD_EN
  // Forward the youngest buffered result: the skid entry when present.
  always_comb begin
    fwd_valid   = 1'b0;
    fwd_rd_addr = out_payload[REG_ADDR_W:1];
    fwd_result  = out_payload[PW-1:REG_ADDR_W+1];
    if (skid_valid) begin
      fwd_valid   = skid_payload[0];
      fwd_rd_addr = skid_payload[REG_ADDR_W:1];
      fwd_result  = skid_payload[PW-1:REG_ADDR_W+1];
    end else if (out_valid) begin
      fwd_valid   = out_payload[0];
    end
  end
`endif

endmodule

// File: tb/tb_ex_result_buffer.sv
// Self-checking bench for ex_result_buffer: queue model compared every cycle plus directed literal checks.
module tb_ex_result_buffer;

  typedef struct {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        wb;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [31:0] ex_result = '0;
  logic [4:0]  ex_rd_addr = '0;
  logic        ex_wb_en = 1'b0;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_result;
  logic [4:0]  mem_rd_addr;
  logic        mem_wb_en;
  logic [1:0]  occupancy;
`ifdef EX_RESULT_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_rd_addr;
  logic [31:0] fwd_result;
`endif

  int     checks = 0;
  int     errors = 0;
  bit     started = 1'b0;
  entry_t q[$];

  always #5 clk = ~clk;

  ex_result_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .ex_valid    (ex_valid),
    .ex_ready    (ex_ready),
    .ex_result   (ex_result),
    .ex_rd_addr  (ex_rd_addr),
    .ex_wb_en    (ex_wb_en),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_result  (mem_result),
    .mem_rd_addr (mem_rd_addr),
    .mem_wb_en   (mem_wb_en),
    .occupancy   (occupancy)
`ifdef EX_RESULT_FWD_EN
    ,
    .fwd_valid   (fwd_valid),
    .fwd_rd_addr (fwd_rd_addr),
    .fwd_result  (fwd_result)
`endif
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] res, input logic [4:0] rd,
                               input logic wb, input logic mr, input logic fl, input logic r);
    @(negedge clk);
    #1;
    ex_valid   = v;
    ex_result  = res;
    ex_rd_addr = rd;
    ex_wb_en   = wb;
    mem_ready  = mr;
    flush      = fl;
    rst        = r;
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Model: a FIFO of at most two entries; input taken only when fewer than two were held last cycle.
  always @(posedge clk) begin
    entry_t e;
    bit     take;
    bit     pop;
    if (rst || flush) begin
      q.delete();
      if (rst) started = 1'b1;
    end else begin
      take = ex_valid && (q.size() < 2);
      pop  = (q.size() > 0) && mem_ready;
      if (pop) void'(q.pop_front());
      if (take) begin
        e.result = ex_result;
        e.rd     = ex_rd_addr;
        e.wb     = ex_wb_en && (ex_rd_addr != 5'd0);
        q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      checkOutput("mem_valid", 64'(mem_valid), 64'(q.size() != 0));
      checkOutput("ex_ready", 64'(ex_ready), 64'(q.size() < 2));
      checkOutput("occupancy", 64'(occupancy), 64'(q.size()));
      if (q.size() != 0) begin
        checkOutput("mem_result", 64'(mem_result), 64'(q[0].result));
        checkOutput("mem_rd_addr", 64'(mem_rd_addr), 64'(q[0].rd));
        checkOutput("mem_wb_en", 64'(mem_wb_en), 64'(q[0].wb));
      end
`ifdef EX_RESULT_FWD_EN
      if (q.size() == 0) begin
        checkOutput("fwd_valid_empty", 64'(fwd_valid), 64'd0);
      end else begin
        checkOutput("fwd_valid", 64'(fwd_valid), 64'(q[$].wb));
        if (q[$].wb) begin
          checkOutput("fwd_rd_addr", 64'(fwd_rd_addr), 64'(q[$].rd));
          checkOutput("fwd_result", 64'(fwd_result), 64'(q[$].result));
        end
      end
`endif
    end
  end

  initial begin
    $display("[TB] start");
    settle();
    settle();
    checkOutput("reset_mem_valid", 64'(mem_valid), 64'd0);
    checkOutput("reset_ex_ready", 64'(ex_ready), 64'd1);
    checkOutput("reset_occupancy", 64'(occupancy), 64'd0);
    checkOutput("reset_mem_result", 64'(mem_result), 64'd0);

    // Streaming at one beat per cycle
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 32'(i), 5'(i), 1'b1, 1'b1, 1'b0, 1'b0);
      settle();
      checkOutput("stream_valid", 64'(mem_valid), 64'd1);
      checkOutput("stream_result", 64'(mem_result), 64'(i));
      checkOutput("stream_ready", 64'(ex_ready), 64'd1);
    end
    applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    settle();
    checkOutput("stream_empty", 64'(mem_valid), 64'd0);

    // Backpressure
    applyStimulus(1'b1, 32'hA, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
    settle();
    checkOutput("bp_occ1", 64'(occupancy), 64'd1);
    checkOutput("bp_ready1", 64'(ex_ready), 64'd1);
    applyStimulus(1'b1, 32'hB, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0);
    settle();
    checkOutput("bp_occ2", 64'(occupancy), 64'd2);
    checkOutput("bp_ready0", 64'(ex_ready), 64'd0);
    applyStimulus(1'b1, 32'hC, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0);
    settle();
    checkOutput("bp_hold_occ", 64'(occupancy), 64'd2);
    checkOutput("bp_hold_a", 64'(mem_result), 64'hA);
    applyStimulus(1'b1, 32'hC, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0);
    settle();
    checkOutput("bp_seq_b", 64'(mem_result), 64'hB);
    checkOutput("bp_occ_b", 64'(occupancy), 64'd1);
    checkOutput("bp_ready_back", 64'(ex_ready), 64'd1);
    applyStimulus(1'b1, 32'hC, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0);
    settle();
    checkOutput("bp_seq_c", 64'(mem_result), 64'hC);
    checkOutput("bp_occ_c", 64'(occupancy), 64'd1);
    applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    settle();
    checkOutput("bp_drained", 64'(mem_valid), 64'd0);

    // Write to x0 loses its write-back enable
    applyStimulus(1'b1, 32'hDEADBEEF, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    settle();
    checkOutput("x0_valid", 64'(mem_valid), 64'd1);
    checkOutput("x0_wb_en", 64'(mem_wb_en), 64'd0);
    checkOutput("x0_result", 64'(mem_result), 64'hDEADBEEF);

    // Flush with both slots full and a pending input
    applyStimulus(1'b1, 32'h33, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    settle();
    checkOutput("fl_pre_occ", 64'(occupancy), 64'd2);
    applyStimulus(1'b1, 32'h77, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0);
    settle();
    checkOutput("fl_valid", 64'(mem_valid), 64'd0);
    checkOutput("fl_occ", 64'(occupancy), 64'd0);
    checkOutput("fl_ready", 64'(ex_ready), 64'd1);
    applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    settle();
    checkOutput("fl_no_ghost", 64'(mem_valid), 64'd0);

    // Flush drops an input that would otherwise be accepted
    applyStimulus(1'b1, 32'h44, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    settle();
    applyStimulus(1'b1, 32'h88, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0);
    settle();
    checkOutput("fl2_occ", 64'(occupancy), 64'd0);
    applyStimulus(1'b1, 32'h91, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    settle();
    applyStimulus(1'b1, 32'h92, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    settle();
    checkOutput("fl3_valid", 64'(mem_valid), 64'd0);
    applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    settle();
    checkOutput("fl3_no_ghost", 64'(mem_valid), 64'd0);

    // Reset in the middle of traffic with both slots held
    applyStimulus(1'b1, 32'h5A, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    settle();
    applyStimulus(1'b1, 32'h5B, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    settle();
    checkOutput("rst_pre_occ", 64'(occupancy), 64'd2);
    applyStimulus(1'b1, 32'h5C, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1);
    settle();
    applyStimulus(1'b1, 32'h5C, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
    settle();
    checkOutput("rst_mem_valid", 64'(mem_valid), 64'd0);
    checkOutput("rst_ex_ready", 64'(ex_ready), 64'd1);
    checkOutput("rst_occupancy", 64'(occupancy), 64'd0);
    checkOutput("rst_mem_result", 64'(mem_result), 64'd0);
    applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    settle();

    // Forwarding of the youngest entry
    applyStimulus(1'b1, 32'h55, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    settle();
`ifdef EX_RESULT_FWD_EN
    checkOutput("fwd1_valid", 64'(fwd_valid), 64'd1);
    checkOutput("fwd1_rd", 64'(fwd_rd_addr), 64'd7);
    checkOutput("fwd1_result", 64'(fwd_result), 64'h55);
`endif
    applyStimulus(1'b1, 32'h66, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    settle();
`ifdef EX_RESULT_FWD_EN
    checkOutput("fwd2_valid", 64'(fwd_valid), 64'd1);
    checkOutput("fwd2_rd", 64'(fwd_rd_addr), 64'd9);
    checkOutput("fwd2_result", 64'(fwd_result), 64'h66);
`endif
    checkOutput("fwd_mem_head", 64'(mem_result), 64'h55);
    applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    settle();
    checkOutput("fwd_drain_66", 64'(mem_result), 64'h66);
    settle();
    settle();
    checkOutput("final_empty", 64'(mem_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
